// File: rtl/stream_rr_arbiter_pkg.sv
// rtl/stream_rr_arbiter_pkg.sv - shared constants and width helper for the stream round-robin arbiter
package stream_rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int CNT_W = 32;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rtl/stream_rr_arbiter_rr_pick.sv - first set request at or after a pointer, searched cyclically
module rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              hit_o
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest set request is the last to write.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        cand  = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_IN);
            if (req_i[cand]) begin
                idx_o = cand;
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin merge of NUM_IN valid/ready streams with burst cap and profiling counters
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_IN       = 4,
    parameter int PAYLOAD_BITS = 128,
    parameter int MAX_BURST    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_IN*PAYLOAD_BITS-1:0]   din,
    input  logic [NUM_IN-1:0]                val_in,
    output logic [NUM_IN-1:0]                ready_upward,
    output logic [PAYLOAD_BITS-1:0]          dout,
    output logic [idx_width(NUM_IN)-1:0]     src_id,
    output logic                             val_out,
    input  logic                             ready_downward,
    input  logic                             clear_cnt,
    output logic [CNT_W-1:0]                 xfer_cnt,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam int IDX_W   = idx_width(NUM_IN);
    localparam int BURST_W = idx_width(MAX_BURST);

    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]      burst_q, burst_d;
    logic [PAYLOAD_BITS-1:0] dout_q;
    logic [IDX_W-1:0]        src_q;
    logic                    val_q;
    logic [CNT_W-1:0]        xfer_q, stall_q;

    logic [PAYLOAD_BITS-1:0] din_arr [NUM_IN];
    logic [IDX_W-1:0]        pick_idx, next_ptr;
    logic                    pick_hit, grant_ready, in_xfer, last_beat;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign din_arr[i] = din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i  (val_in),
        .ptr_i  (rr_ptr_q),
        .idx_o  (pick_idx),
        .hit_o  (pick_hit)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign grant_ready = ~val_q | ready_downward;
    assign in_xfer     = (state_q == ST_GRANT) & val_in[grant_q] & grant_ready;
    assign last_beat   = (burst_q == BURST_W'(MAX_BURST - 1));
    assign next_ptr    = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        ready_upward = '0;
        if (state_q == ST_GRANT) begin
            ready_upward[grant_q] = grant_ready;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        if (state_q == ST_IDLE) begin
            if (pick_hit) begin
                grant_d = pick_idx;
                burst_d = '0;
                state_d = ST_GRANT;
            end
        end else begin
            if (in_xfer) begin
                burst_d = burst_q + BURST_W'(1);
            end
            // A blocked output with the requester still valid falls through and holds everything.
            if ((in_xfer && last_beat) || !val_in[grant_q]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
                burst_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            src_q  <= '0;
            val_q  <= 1'b0;
        end else if (in_xfer) begin
            dout_q <= din_arr[grant_q];
            src_q  <= grant_q;
            val_q  <= 1'b1;
        end else if (ready_downward) begin
            val_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else if (clear_cnt) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (val_q && ready_downward) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
            if (val_q && !ready_downward) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign dout      = dout_q;
    assign src_id    = src_q;
    assign val_out   = val_q;
    assign xfer_cnt  = xfer_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - scoreboard bench for stream_rr_arbiter
module tb_stream_rr_arbiter;

    localparam int NI = 4;
    localparam int PB = 128;

    typedef struct packed {
        logic [1:0]    src;
        logic [PB-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NI*PB-1:0] din;
    logic [NI-1:0]    val_in;
    logic [NI-1:0]    ready_upward;
    logic [PB-1:0]    dout;
    logic [1:0]       src_id;
    logic             val_out;
    logic             ready_downward;
    logic             clear_cnt;
    logic [31:0]      xfer_cnt;
    logic [31:0]      stall_cnt;

    int            checks   = 0;
    int            failures = 0;
    logic [PB-1:0] srcq [NI][$];
    beat_t         exp_q [$];
    int            cyc      = 0;
    bit            gap_chk  = 1'b0;
    int            last_cyc = -1;
    logic [1:0]    last_src = '0;
    logic [31:0]   salt     = '0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_IN       (NI),
        .PAYLOAD_BITS (PB),
        .MAX_BURST    (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din            (din),
        .val_in         (val_in),
        .ready_upward   (ready_upward),
        .dout           (dout),
        .src_id         (src_id),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .clear_cnt      (clear_cnt),
        .xfer_cnt       (xfer_cnt),
        .stall_cnt      (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk(input int r, input int k);
        return {salt, 32'(r), 32'(k), ~salt ^ 32'(k * 13)};
    endfunction

    task automatic src_push(input int r, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) srcq[r].push_back(mk(r, k));
    endtask

    task automatic exp_push(input int r, input int k0, input int n);
        beat_t b;
        for (int k = k0; k < k0 + n; k++) begin
            b.src  = 2'(r);
            b.data = mk(r, k);
            exp_q.push_back(b);
        end
    endtask

    function automatic int pending();
        int s = exp_q.size() + int'(val_out);
        for (int r = 0; r < NI; r++) s += srcq[r].size();
        return s;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mid();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (pending() != 0 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_drain"}, PB'(pending()), '0);
    endtask

    // Sources present queue heads at negedge; both input and output handshakes are sampled 1ns later.
    initial begin
        beat_t e;
        val_in = '0;
        din    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int r = 0; r < NI; r++) begin
                if (srcq[r].size() > 0) begin
                    val_in[r]          = 1'b1;
                    din[r*PB +: PB]    = srcq[r][0];
                end else begin
                    val_in[r] = 1'b0;
                end
            end
            #1;
            if (rst_n) begin
                for (int r = 0; r < NI; r++) begin
                    if (val_in[r] && ready_upward[r]) void'(srcq[r].pop_front());
                end
                if (val_out && ready_downward) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", PB'(val_out), '0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("dout", dout, e.data);
                        check_eq("src_id", PB'(src_id), PB'(e.src));
                        if (gap_chk && last_cyc >= 0)
                            check_eq("beat_gap", PB'(cyc - last_cyc), PB'((e.src == last_src) ? 1 : 2));
                        last_cyc = cyc;
                        last_src = e.src;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        ready_downward = 1'b1;
        clear_cnt      = 1'b0;
        salt           = $urandom;

        step(3);
        #2;
        check_eq("rst_val_out", PB'(val_out), '0);
        check_eq("rst_dout", dout, '0);
        check_eq("rst_src_id", PB'(src_id), '0);
        check_eq("rst_xfer", PB'(xfer_cnt), '0);
        check_eq("rst_stall", PB'(stall_cnt), '0);
        check_eq("rst_ready", PB'(ready_upward), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_eq("ready_after_rst", PB'(ready_upward), '0);

        // single requester 2, five beats
        mid();
        salt = $urandom;
        src_push(2, 0, 5);
        exp_push(2, 0, 5);
        gap_chk  = 1'b1;
        last_cyc = -1;
        @(negedge clk); #2;
        check_eq("idle_ready", PB'(ready_upward), '0);
        @(negedge clk); #2;
        check_eq("grant2_ready", PB'(ready_upward), PB'(4'b0100));
        @(negedge clk); #2;
        check_eq("lat_val_out", PB'(val_out), PB'(1));
        check_eq("lat_src_id", PB'(src_id), PB'(2));
        wait_drain("single");
        gap_chk = 1'b0;
        step(2); #2;
        check_eq("rr_ptr_after_2", PB'(dut.rr_ptr_q), PB'(3));
        check_eq("idle_after_2", PB'(dut.state_q), '0);

        // one beat from 3 moves the pointer to 0, then all four stream continuously
        mid();
        src_push(3, 0, 1);
        exp_push(3, 0, 1);
        wait_drain("wrap");
        step(2);
        mid();
        salt = $urandom;
        for (int r = 0; r < NI; r++) src_push(r, 0, 16);
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < NI; r++) exp_push(r, rnd * 8, 8);
        gap_chk  = 1'b1;
        last_cyc = -1;
        wait_drain("all_four");
        gap_chk = 1'b0;
        step(2);

        // ten-cycle downstream stall in the middle of requester 1's stream
        @(negedge clk); clear_cnt = 1'b1;
        @(negedge clk); clear_cnt = 1'b0;
        #2;
        check_eq("cleared_xfer", PB'(xfer_cnt), '0);
        mid();
        salt = $urandom;
        src_push(1, 0, 12);
        exp_push(1, 0, 12);
        step(3);
        @(negedge clk);
        ready_downward = 1'b0;
        #2;
        check_eq("stall_entry_valid", PB'(val_out), PB'(1));
        for (int i = 0; i < 10; i++) begin
            if (i > 0) #2;
            check_eq("stall_cnt_run", PB'(stall_cnt), PB'(i));
            check_eq("stall_ready", PB'(ready_upward), '0);
            check_eq("stall_dout", dout, exp_q[0].data);
            check_eq("stall_src", PB'(src_id), PB'(1));
            @(negedge clk);
        end
        ready_downward = 1'b1;
        #2;
        check_eq("stall_cnt_10", PB'(stall_cnt), PB'(10));
        wait_drain("stall");
        check_eq("stall_xfer_total", PB'(xfer_cnt), PB'(12));
        check_eq("stall_cnt_final", PB'(stall_cnt), PB'(10));
        step(2);

        // pointer at 1 with requesters 0 and 3 valid: 3 wins first
        mid();
        src_push(0, 0, 1);
        exp_push(0, 0, 1);
        wait_drain("ptr_one");
        step(2); #2;
        check_eq("rr_ptr_1", PB'(dut.rr_ptr_q), PB'(1));
        mid();
        salt = $urandom;
        src_push(3, 0, 2);
        src_push(0, 1, 2);
        exp_push(3, 0, 2);
        exp_push(0, 1, 2);
        wait_drain("ptr_wrap_order");
        step(2);

        // clear in the same cycle as an output handshake
        mid();
        salt = $urandom;
        src_push(1, 0, 3);
        exp_push(1, 0, 3);
        step(3); #2;
        check_eq("clr_val_out", PB'(val_out), PB'(1));
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        #2;
        check_eq("clear_priority", PB'(xfer_cnt), '0);
        wait_drain("clear");
        check_eq("clear_xfer_after", PB'(xfer_cnt), PB'(2));
        step(2);

        // asynchronous reset while a burst is in flight
        mid();
        salt = $urandom;
        src_push(2, 0, 8);
        exp_push(2, 0, 8);
        step(4);
        @(posedge clk); #2;
        check_eq("pre_rst_valid", PB'(val_out), PB'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_val_out", PB'(val_out), '0);
        check_eq("mid_rst_dout", dout, '0);
        check_eq("mid_rst_xfer", PB'(xfer_cnt), '0);
        check_eq("mid_rst_stall", PB'(stall_cnt), '0);
        check_eq("mid_rst_ready", PB'(ready_upward), '0);
        for (int r = 0; r < NI; r++) srcq[r].delete();
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        #2;
        check_eq("post_rst_ready", PB'(ready_upward), '0);
        mid();
        salt = $urandom;
        src_push(3, 0, 2);
        src_push(0, 0, 2);
        exp_push(0, 0, 2);
        exp_push(3, 0, 2);
        wait_drain("post_rst");
        check_eq("post_rst_xfer", PB'(xfer_cnt), PB'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
